mike_cacheline_adaptor: RTL
===========================

# mike_cacheline_adaptor

Memory-side responder for the cache's physical-memory port. It accepts 256-bit line read (fill) and line write (writeback) requests from the cache datapath and control, and converts each into a 4-beat × 64-bit burst on the main-memory bus. When the burst completes it returns a single-cycle `resp_o` to the cache. It sits between the 2-way cache and main memory or the arbiter.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles without `resp_i` before a burst is abandoned. Used only with `MIKE_ADAPTOR_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `address_i`  in  32  cache line address; bits [4:0] are ignored.
- `line_i`  in  256  writeback line from the cache.
- `read_i`  in  1  line fill request.
- `write_i`  in  1  line writeback request.
- `line_o`  out  256  assembled fill line.
- `resp_o`  out  1  one-cycle completion pulse to the cache.
- `err_o`  out  1  timeout abort flag; qualifies `resp_o`.
- `address_o`  out  32  burst address to memory, equal to {latched addr[31:5], 5'b0}.
- `burst_o`  out  64  write beat data.
- `burst_i`  in  64  read beat data.
- `read_o`  out  1  memory burst read request.
- `write_o`  out  1  memory burst write request.
- `resp_i`  in  1  memory beat strobe; one beat is transferred per cycle in which it is high.

## Operation
States:
- IDLE
- RD
- WR
- DONE
- ERR (exists only with `MIKE_ADAPTOR_TIMEOUT_EN`)

Transitions:
- IDLE: on `write_i` go to WR; otherwise on `read_i` go to RD. `write_i` has priority if both are high.
- At acceptance:
  - latch `address_i[31:5]`;
  - latch `line_i` (write only);
  - clear the 2-bit beat counter `cnt`.
- RD: `read_o`=1. Each cycle with `resp_i`=1 stores `burst_i` into line bits [64·cnt+63 : 64·cnt], then increments `cnt`. The beat with `cnt`=3 moves the block to DONE.
- WR: `write_o`=1. `burst_o` = latched line [64·cnt+63 : 64·cnt], combinational from `cnt`. Each `resp_i` advances `cnt`. The beat with `cnt`=3 moves the block to DONE.
- DONE: `resp_o`=1 for exactly one cycle, then IDLE.

Output rules:
- `line_o` holds the last completed fill until the next fill's first beat overwrites it.
- `burst_o` = 0 outside WR.
- `address_o` is held stable from acceptance until leaving RD/WR.

Request rules:
- Requests are sampled only in IDLE.
- `read_i`/`write_i` changes during RD/WR/DONE are ignored.
- The requester must drop its request by the cycle after `resp_o`. A request still high in IDLE starts a new burst.

Beat handling:
- `resp_i` in IDLE or DONE is ignored.
- Beats with `resp_i` low are stalls: `cnt` holds and data is unchanged.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE, `cnt`=0;
  - `resp_o`, `err_o`, `read_o`, `write_o` = 0;
  - `address_o`=0, `burst_o`=0, `line_o`=0.
- Request sampled in IDLE at cycle 0 → `read_o`/`write_o` high from cycle 1.
- With `resp_i` high continuously in cycles 1–4:
  - `resp_o` is high in cycle 5;
  - `read_o`/`write_o` fall in cycle 5.
- Minimum latency is 5 cycles, plus 1 cycle per stall.
- `read_o`/`write_o` stay high through the cycle of the 4th beat.
- Back-to-back requests: the earliest next acceptance is cycle 6 (IDLE).

## Configuration
- `MIKE_ADAPTOR_TIMEOUT_EN` defined:
  - An 8-bit-or-wider stall counter clears on acceptance and on every `resp_i`, and increments in RD/WR while `resp_i`=0.
  - When the counter reaches `TIMEOUT`, the block goes to ERR: `resp_o`=1 and `err_o`=1 for one cycle, then IDLE.
  - Partial `line_o` contents are undefined after an abort.
- Not defined:
  - No counter and no ERR state; the block waits indefinitely for `resp_i`.
  - `err_o` is tied to 0.

## Test plan
- Reset mid-RD after 2 beats → all outputs 0 immediately, IDLE. Then `read_i` with address 0x0000_1234 → `address_o`=0x0000_1220 in cycle 1.
- Fill with beats 0x1111…, 0x2222…, 0x3333…, 0x4444…, `resp_i` continuous → `line_o`={0x4444…,0x3333…,0x2222…,0x1111…} and `resp_o` in cycle 5, single cycle.
- Writeback of `line_i`=256'h{D3,D2,D1,D0} with `resp_i` stalled 1 cycle between each beat → `burst_o` sequence D0,D1,D2,D3 and `resp_o` in cycle 8.
- `read_i` and `write_i` both high in IDLE → `write_o`=1, `read_o`=0. Toggling `address_i` mid-burst leaves `address_o` unchanged.
- Stray `resp_i` in IDLE and DONE → no state change, `line_o` unchanged. Request held high one extra cycle after `resp_o` → second burst starts.
- With macro, `TIMEOUT`=4, no `resp_i` after `read_o` → `resp_o`=`err_o`=1 in cycle 5, then IDLE. Without macro → `read_o` stays high for 100+ cycles and `err_o`=0.

Source files
------------

// File: rtl/mike_cacheline_adaptor.sv
// mike_cacheline_adaptor
//   Memory-side responder for the cache's physical-memory port. Each 256-bit
//   line fill or writeback from the cache becomes a 4-beat x 64-bit burst on
//   the main-memory bus. A single-cycle resp_o is returned when the burst ends.
//
// Optional feature macro: MIKE_ADAPTOR_TIMEOUT_EN
//   When defined, a burst that sees TIMEOUT consecutive cycles without resp_i
//   is abandoned through an ERR state (resp_o and err_o high for one cycle).
//   When undefined, the block waits forever and err_o is tied low.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   address_i  : cache line address (bits [4:0] ignored)
//   line_i     : writeback line from the cache
//   read_i     : line fill request
//   write_i    : line writeback request (wins over read_i)
//   line_o     : assembled fill line
//   resp_o     : one-cycle completion pulse
//   err_o      : timeout abort flag, qualifies resp_o
//   address_o  : burst address {latched addr[31:5], 5'b0}
//   burst_o    : write beat data (0 outside a write burst)
//   burst_i    : read beat data
//   read_o     : memory burst read request
//   write_o    : memory burst write request
//   resp_i     : memory beat strobe, one beat per high cycle
module mike_cacheline_adaptor #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic [255:0] line_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic         err_o,
  output logic [31:0]  address_o,
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef MIKE_ADAPTOR_TIMEOUT_EN
  localparam logic [2:0] S_ERR  = 3'd4;
`endif

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic [1:0]   r_cnt;
  logic [26:0]  r_addr;
  logic [255:0] r_wline;
  logic [255:0] r_rline;
  logic         r_read;
  logic         r_write;
  logic         r_resp;
  logic         w_busy;
  logic         w_beat;
  logic         w_last;
  logic         w_accept;
  logic         w_resp_next;
  logic         w_unused_addr;

  assign w_busy   = (r_state == S_RD) || (r_state == S_WR);
  assign w_beat   = w_busy && resp_i;
  assign w_last   = w_beat && (r_cnt == 2'd3);
  assign w_accept = (r_state == S_IDLE) && (read_i || write_i);

  // Low address bits select bytes inside the line and never reach memory.
  assign w_unused_addr = ^address_i[4:0];

`ifdef MIKE_ADAPTOR_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 32'd1);

  logic [15:0] r_stall;
  logic        r_err;
  logic        w_abort;

  // Abort on the stall cycle that would make the count reach TIMEOUT, so
  // ERR is presented exactly TIMEOUT stall cycles after the burst starts.
  assign w_abort     = w_busy && !resp_i && (r_stall == STALL_LIMIT);
  assign w_resp_next = (w_next == S_DONE) || (w_next == S_ERR);
  assign err_o       = r_err;

  // Stall counter: cleared by acceptance or any beat, counts idle bus cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= 16'd0;
    end else if (w_accept || resp_i) begin
      r_stall <= 16'd0;
    end else if (w_busy) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  // Error flag register, raised alongside resp_o on an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_next == S_ERR);
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 32'd0);
  assign w_resp_next      = (w_next == S_DONE);
  assign err_o            = 1'b0;
`endif

  // Next-state decode; requests are only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (write_i) begin
          w_next = S_WR;
        end else if (read_i) begin
          w_next = S_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD, S_WR: begin
        if (w_last) begin
          w_next = S_DONE;
`ifdef MIKE_ADAPTOR_TIMEOUT_EN
        end else if (w_abort) begin
          w_next = S_ERR;
`endif
        end else begin
          w_next = r_state;
        end
      end
      S_DONE:  w_next = S_IDLE;
`ifdef MIKE_ADAPTOR_TIMEOUT_EN
      S_ERR:   w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered handshake outputs decoded from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_read  <= (w_next == S_RD);
      r_write <= (w_next == S_WR);
      r_resp  <= w_resp_next;
    end
  end

  // Request capture at acceptance and beat counter advance on each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_addr  <= 27'd0;
      r_wline <= 256'd0;
    end else if (w_accept) begin
      r_cnt  <= 2'd0;
      r_addr <= address_i[31:5];
      if (write_i) begin
        r_wline <= line_i;
      end
    end else if (w_beat) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Fill assembly: each read beat lands in the 64-bit lane selected by cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rline <= 256'd0;
    end else if ((r_state == S_RD) && resp_i) begin
      r_rline[{r_cnt, 6'd0} +: 64] <= burst_i;
    end
  end

  assign line_o    = r_rline;
  assign address_o = {r_addr, 5'd0};
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;
  assign burst_o   = r_write ? r_wline[{r_cnt, 6'd0} +: 64] : 64'd0;

endmodule
